// File: rtl/sram_controller_pkg.sv
// Shared types and widths for the 32-bit CPU to 16-bit SRAM bridge.
package sram_ctrl_pkg;
  localparam int          SRAM_AW       = 18;
  localparam int          SRAM_DW       = 16;
  localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;

  // Latched access: word index is already mapped into SRAM space.
  typedef struct packed {
    logic                 wr;
    logic [SRAM_AW-2:0]   widx;
    logic [31:0]          data;
  } req_t;
endpackage

// File: rtl/sram_controller_if.sv
// CPU memory-stage side of the SRAM bridge.
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (output wr_en, rd_en, address, write_data, input read_data, ready);
  modport slave  (input wr_en, rd_en, address, write_data, output read_data, ready);
endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into two 16-bit SRAM half-word cycles,
// holding ready low (pipeline freeze) while the access is in flight.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int          SRAM_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  sram_controller_if.slave   cpu,
  output logic               SRAM_WE_N,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ
);
  localparam int CW = $clog2(SRAM_CYCLES) + 1;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  req_t               req_q, req_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               we_n_q, we_n_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;

  logic [31:0]        off;
  logic               last;
  logic               drive_dq;
  logic [SRAM_DW-1:0] dq_out;
  logic               unused_off;

  assign off        = cpu.address - BASE_ADDR;
  assign unused_off = ^{off[31:19], off[1:0]};
  assign last       = (cnt_q == CW'(SRAM_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      we_n_q  <= 1'b1;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      we_n_q  <= we_n_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    case (state_q)
      IDLE: if (cpu.wr_en || cpu.rd_en) begin
        state_d    = LOW;
        cnt_d      = '0;
        req_d.wr   = cpu.wr_en;
        req_d.widx = off[18:2];
        req_d.data = cpu.write_data;
      end
      LOW: if (last) begin
        state_d = HIGH;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      HIGH: if (last) begin
        state_d = DONE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // SRAM pins are registered from the next state so they only move on edges.
  always_comb begin
    we_n_d  = 1'b1;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    if (state_d == LOW || state_d == HIGH) begin
      addr_d = {req_d.widx, state_d == HIGH};
      we_n_d = !req_d.wr;
    end
    if (!req_q.wr && last) begin
      if (state_q == LOW)  rdata_d[15:0]  = SRAM_DQ;
      if (state_q == HIGH) rdata_d[31:16] = SRAM_DQ;
    end
  end

  assign drive_dq = req_q.wr && (state_q == LOW || state_q == HIGH);
  assign dq_out   = (state_q == HIGH) ? req_q.data[31:16] : req_q.data[15:0];
  assign SRAM_DQ  = drive_dq ? dq_out : 'z;

  assign SRAM_WE_N     = we_n_q;
  assign SRAM_ADDR     = addr_q;
  assign cpu.read_data = rdata_q;
  assign cpu.ready     = (state_q == DONE) ||
                         (state_q == IDLE && !cpu.wr_en && !cpu.rd_en);
endmodule

// File: doc/sram_controller.md
# sram_controller

Bridges the CPU memory stage and the external 16-bit SRAM. It turns each 32-bit word load or store into two sequential 16-bit SRAM half-word cycles. While an access is in flight it holds `ready` low, which freezes the pipeline. It sits between `ARM_cpu`'s memory stage and the `SRAM_WE_N`/`SRAM_DQ`/`SRAM_ADDR` pins.

## Interface
Parameters:
- `SRAM_CYCLES`, 2: clock cycles spent on each half-word access (≥1).
- `BASE_ADDR`, 1024: CPU byte address that maps to SRAM word 0.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `wr_en` in 1: store request from the memory stage.
- `rd_en` in 1: load request from the memory stage.
- `address` in 32: CPU byte address.
- `write_data` in 32: store data.
- `read_data` out 32: load result, registered.
- `ready` out 1: high when the memory stage may advance; low means freeze.
- `SRAM_WE_N` out 1: SRAM write strobe, active-low.
- `SRAM_ADDR` out 18: SRAM half-word address.
- `SRAM_DQ` inout 16: bidirectional data; driven only during writes, otherwise high-Z.

## Operation
- State machine states: IDLE, LOW, HIGH, DONE.
- **IDLE**
  - If `wr_en` or `rd_en` is high, latch `address`, `write_data` and the operation (write takes precedence if both are high), then go to LOW.
- **LOW**
  - Access the low half-word for `SRAM_CYCLES` cycles, then go to HIGH.
- **HIGH**
  - Access the high half-word for `SRAM_CYCLES` cycles, then go to DONE.
- **DONE**
  - One cycle, then return to IDLE unconditionally.
- Address mapping:
  - `off = address - BASE_ADDR`, a 32-bit subtraction.
  - `SRAM_ADDR = {off[18:2], half}`, with half=0 in LOW and half=1 in HIGH.
  - `off[1:0]` is ignored (word-aligned accesses only).
  - Higher bits are discarded, so addresses wrap modulo 2^18 half-words.
- Writes:
  - `SRAM_DQ` = latched data `[15:0]` in LOW and `[31:16]` in HIGH.
  - `SRAM_WE_N` is low for every LOW/HIGH cycle of a write.
- Reads:
  - `SRAM_DQ` is released (high-Z).
  - `SRAM_DQ` is sampled into `read_data[15:0]` on the last LOW cycle and into `read_data[31:16]` on the last HIGH cycle.
  - `read_data` holds its value until the next read. Writes do not alter it.
- `ready` (combinational from registered state):
  - High in DONE.
  - High in IDLE when neither `rd_en` nor `wr_en` is high.
  - Low otherwise, including in IDLE while a request is present.
- Request inputs are ignored outside IDLE. Dropping or changing them mid-access does not affect the latched access.
- A wait counter sized `$clog2(SRAM_CYCLES)+1` bits counts cycles within LOW and HIGH. It is cleared on every state entry.

## Timing
- Reset values: state IDLE, `read_data`=0, `SRAM_WE_N`=1, `SRAM_ADDR`=0, `SRAM_DQ`=Z.
- `ready` is 1 whenever no request is present.
- Access from request cycle 0 with `SRAM_CYCLES`=N:
  - LOW occupies cycles 1..N.
  - HIGH occupies cycles N+1..2N.
  - DONE is cycle 2N+1, with `ready`=1 and `read_data` valid.
  - The stage advances on the edge ending cycle 2N+1.
  - The next request can be latched in cycle 2N+2.
  - With N=2: 5 stall cycles, and `ready` rises in cycle 5.
- Back-to-back requests: IDLE is visited for one cycle between accesses. No bypass.
- Reset asserted mid-operation:
  - Immediate, asynchronous return to IDLE.
  - `SRAM_WE_N`=1 and `SRAM_DQ`=Z at once.
  - A partially written word is left as is. A partially read `read_data` is cleared to 0.
- `SRAM_ADDR`/`SRAM_WE_N` change only at rising edges, so they are glitch-free relative to SRAM sampling.

## Structure
- Shared package `sram_ctrl_pkg` holds:
  - the state enum (IDLE, LOW, HIGH, DONE);
  - `BASE_ADDR` default;
  - the `SRAM_AW`=18 and `SRAM_DW`=16 widths.
- Flat module; no sub-module is needed. The wait counter and the address mapping are in-line.
- The `SRAM_DQ` tristate is a single continuous assignment gated by write-in-LOW/HIGH.

## Test plan
- **Write:** write 0xDEADBEEF at 1024 → half-word 0 = 0xBEEF, half-word 1 = 0xDEAD. `SRAM_WE_N` low for cycles 1–4, `ready` rises in cycle 5.
- **Read:** read at 1024 after the write → `read_data`=0xDEADBEEF in cycle 5, `SRAM_DQ` high-Z throughout.
- **Mapping:** write 0x12345678 at 1028 → `SRAM_ADDR` 2 then 3. Read at 1030 returns 0x12345678 (`[1:0]` ignored).
- **Simultaneous:** `wr_en`=`rd_en`=1, `write_data`=0xA5A5_5A5A at 1032 → write performed, `read_data` unchanged.
- **Reset mid-write:** `rst` low in cycle 2 → `SRAM_WE_N`=1 and `SRAM_DQ`=Z in the same cycle. After release, the state is IDLE and `ready`=1.
- **Back-to-back:** back-to-back reads held continuously → one access every 6 cycles (N=2). Request changed mid-access has no effect.
